// File: rtl/regfile_wr_arb_async_rst.sv
// Round-robin write arbiter feeding a single register-file write port.
// Optional grant statistics counters are enabled with `define REGFILE_WR_ARB_STATS_EN.
module regfile_wr_arb_async_rst #(
    parameter int WIDTH = 32,
    parameter int N_REG = 32,
    parameter int N_REQ = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_REQ-1:0]                        req_valid,
    input  logic [N_REQ-1:0][$clog2(N_REG)-1:0]     req_addr,
    input  logic [N_REQ-1:0][WIDTH-1:0]             req_data,
    output logic [N_REQ-1:0]                        req_ready,
    output logic                                    wen,
    output logic [$clog2(N_REG)-1:0]                waddr,
    output logic [WIDTH-1:0]                        wdata,
    output logic [N_REG-1:0]                        wr_pending,
    output logic                                    err_oor
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    input  logic                                    cnt_clr,
    output logic [N_REQ-1:0][15:0]                  grant_cnt
`endif
);

    localparam int AW = $clog2(N_REG);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    nxt_ptr;
    logic [PW-1:0]    cand;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_vld;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             sel_oor;

    logic             wen_p1;
    logic             err_p1;
    logic [AW-1:0]    waddr_p1;
    logic [WIDTH-1:0] wdata_p1;

    // ---- stage p0: combinational round-robin search starting at rr_ptr ----
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = PW'((int'(rr_ptr) + i) % N_REQ);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready          = '0;
        req_ready[gnt_idx] = gnt_vld;
    end

    assign sel_addr = req_addr[gnt_idx];
    assign sel_data = req_data[gnt_idx];
    // Only reachable when N_REG is not a power of two.
    assign sel_oor  = (32'(sel_addr) >= N_REG);
    assign nxt_ptr  = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);

    // ---- stage p1: registered write port ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            wen_p1   <= 1'b0;
            err_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            if (gnt_vld) begin
                rr_ptr <= nxt_ptr;
            end
            wen_p1 <= gnt_vld & ~sel_oor;
            err_p1 <= gnt_vld & sel_oor;
            if (gnt_vld && !sel_oor) begin
                waddr_p1 <= sel_addr;
                wdata_p1 <= sel_data;
            end
        end
    end

    assign wen     = wen_p1;
    assign waddr   = waddr_p1;
    assign wdata   = wdata_p1;
    assign err_oor = err_p1;

    always_comb begin
        wr_pending = '0;
        if (wen_p1) begin
            wr_pending[waddr_p1] = 1'b1;
        end
    end

`ifdef REGFILE_WR_ARB_STATS_EN
    // Per-producer saturating grant counters; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (cnt_clr) begin
                    grant_cnt[k] <= '0;
                end else if (gnt_vld && gnt_idx == PW'(k) && grant_cnt[k] != 16'hFFFF) begin
                    grant_cnt[k] <= grant_cnt[k] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_arb_async_rst.sv
// Self-checking bench for regfile_wr_arb_async_rst with a behavioural reference model.
// Exercises REGFILE_WR_ARB_STATS_EN counters only when that macro is defined.
module tb_regfile_wr_arb_async_rst;

    localparam int WIDTH = 32;
    localparam int N_REG = 20;
    localparam int N_REQ = 4;
    localparam int AW    = $clog2(N_REG);

    logic                          clk = 1'b0;
    logic                          rst;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0][AW-1:0]      req_addr;
    logic [N_REQ-1:0][WIDTH-1:0]   req_data;
    logic [N_REQ-1:0]              req_ready;
    logic                          wen;
    logic [AW-1:0]                 waddr;
    logic [WIDTH-1:0]              wdata;
    logic [N_REG-1:0]              wr_pending;
    logic                          err_oor;
    logic                          cnt_clr;
`ifdef REGFILE_WR_ARB_STATS_EN
    logic [N_REQ-1:0][15:0]        grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int               m_rr;
    logic             m_wen;
    logic             m_err;
    logic [AW-1:0]    m_waddr;
    logic [WIDTH-1:0] m_wdata;
    int               m_cnt [N_REQ];

    regfile_wr_arb_async_rst #(
        .WIDTH(WIDTH),
        .N_REG(N_REG),
        .N_REQ(N_REQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .wr_pending (wr_pending),
        .err_oor    (err_oor)
`ifdef REGFILE_WR_ARB_STATS_EN
        ,
        .cnt_clr    (cnt_clr),
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model_win();
        for (int i = 0; i < N_REQ; i++) begin
            int k;
            k = (m_rr + i) % N_REQ;
            if (req_valid[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] exp_ready();
        int w;
        exp_ready = '0;
        w = model_win();
        if (w >= 0) exp_ready[w] = 1'b1;
    endfunction

    function automatic logic [N_REG-1:0] exp_pending();
        exp_pending = '0;
        if (m_wen) exp_pending[m_waddr] = 1'b1;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_wen = 1'b0; m_err = 1'b0; m_waddr = '0; m_wdata = '0;
        for (int k = 0; k < N_REQ; k++) m_cnt[k] = 0;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic clock_cycle();
        int w;
        w = model_win();
        @(posedge clk);
        if (w >= 0) begin
            m_rr = (w + 1) % N_REQ;
            if (int'(req_addr[w]) < N_REG) begin
                m_wen = 1'b1; m_err = 1'b0;
                m_waddr = req_addr[w]; m_wdata = req_data[w];
            end else begin
                m_wen = 1'b0; m_err = 1'b1;
            end
        end else begin
            m_wen = 1'b0; m_err = 1'b0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (cnt_clr) m_cnt[k] = 0;
            else if (k == w && m_cnt[k] < 65535) m_cnt[k] = m_cnt[k] + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({wen, waddr, wdata, err_oor, wr_pending, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got wen=%b waddr=%0d wdata=%h err=%b pend=%h ready=%b required all 0",
                     wen, waddr, wdata, err_oor, wr_pending, req_ready);
        end
        rst = 1'b0;
        model_reset();
        // Move rr_ptr to 3 so a post-reset restart at index 0 is observable.
        req_valid = 4'b0100; req_addr[2] = 5'd9; req_data[2] = $urandom;
        #1;
        clock_cycle();
        req_valid = '0;
        n_checks++;
        if (wen !== 1'b1 || waddr !== 5'd9 || wr_pending !== 20'h00200) begin
            n_fail++;
            $display("FAIL reset_prewrite got wen=%b waddr=%0d pend=%h required 1/9/00200", wen, waddr, wr_pending);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({wen, waddr, wdata, err_oor, wr_pending} !== '0) begin
            n_fail++;
            $display("FAIL reset_async got wen=%b waddr=%0d wdata=%h err=%b pend=%h required all 0",
                     wen, waddr, wdata, err_oor, wr_pending);
        end
        req_valid = 4'b1001;
        req_addr[0] = 5'd11; req_data[0] = $urandom;
        req_addr[3] = 5'd12; req_data[3] = $urandom;
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_restart_ready got %b required 0001", req_ready);
        end
        clock_cycle();
        req_valid = '0;
        n_checks++;
        if (wen !== 1'b1 || waddr !== 5'd11 || wdata !== req_data[0]) begin
            n_fail++;
            $display("FAIL reset_restart_write got wen=%b waddr=%0d wdata=%h required 1/11/%h",
                     wen, waddr, wdata, req_data[0]);
        end
    endtask

    task automatic test_fairness();
        logic [N_REQ-1:0] exp;
        do_reset();
        for (int k = 0; k < N_REQ; k++) begin
            req_addr[k] = AW'(k + 1);
            req_data[k] = $urandom;
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp = '0;
            exp[c % N_REQ] = 1'b1;
            n_checks++;
            if (req_ready !== exp) begin
                n_fail++;
                $display("FAIL fair_ready cycle=%0d got %b required %b", c, req_ready, exp);
            end
            clock_cycle();
            n_checks++;
            if (wen !== 1'b1 || int'(waddr) != (c % N_REQ) + 1 || wdata !== req_data[c % N_REQ]) begin
                n_fail++;
                $display("FAIL fair_write cycle=%0d got wen=%b waddr=%0d wdata=%h required 1/%0d/%h",
                         c, wen, waddr, wdata, (c % N_REQ) + 1, req_data[c % N_REQ]);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_rotation();
        do_reset();
        req_addr[2] = 5'd7; req_addr[0] = 5'd8; req_addr[3] = 5'd9;
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rot_first got %b required 0100", req_ready);
        end
        clock_cycle();
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000 || $countones(req_ready) > 1) begin
            n_fail++;
            $display("FAIL rot_second got %b required 1000", req_ready);
        end
        clock_cycle();
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rot_third got %b required 0001", req_ready);
        end
        clock_cycle();
        req_valid = '0;
    endtask

    task automatic test_collision();
        do_reset();
        req_addr[0] = 5'd5; req_data[0] = 32'h0000AAAA;
        req_addr[1] = 5'd5; req_data[1] = 32'h0000BBBB;
        req_valid = 4'b0011;
        #1;
        clock_cycle();
        req_valid = 4'b0010;
        n_checks++;
        if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h0000AAAA || wr_pending !== 20'h00020) begin
            n_fail++;
            $display("FAIL coll_first got wen=%b waddr=%0d wdata=%h pend=%h required 1/5/0000aaaa/00020",
                     wen, waddr, wdata, wr_pending);
        end
        #1;
        clock_cycle();
        req_valid = '0;
        n_checks++;
        if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h0000BBBB || wr_pending !== 20'h00020) begin
            n_fail++;
            $display("FAIL coll_second got wen=%b waddr=%0d wdata=%h pend=%h required 1/5/0000bbbb/00020",
                     wen, waddr, wdata, wr_pending);
        end
        #1;
        clock_cycle();
        n_checks++;
        if (wen !== 1'b0 || wr_pending !== '0) begin
            n_fail++;
            $display("FAIL coll_idle got wen=%b pend=%h required 0/00000", wen, wr_pending);
        end
    endtask

    task automatic test_out_of_range();
        logic [WIDTH-1:0] keep;
        do_reset();
        keep = $urandom;
        req_addr[0] = 5'd6; req_data[0] = keep;
        req_valid = 4'b0001;
        #1;
        clock_cycle();
        req_addr[2] = 5'd25; req_data[2] = ~keep;
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL oor_ready got %b required 0100", req_ready);
        end
        clock_cycle();
        req_valid = '0;
        n_checks++;
        if (err_oor !== 1'b1 || wen !== 1'b0 || waddr !== 5'd6 || wdata !== keep || wr_pending !== '0) begin
            n_fail++;
            $display("FAIL oor_pulse got err=%b wen=%b waddr=%0d wdata=%h pend=%h required 1/0/6/%h/0",
                     err_oor, wen, waddr, wdata, wr_pending, keep);
        end
        #1;
        clock_cycle();
        n_checks++;
        if (err_oor !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_clear got err=%b required 0", err_oor);
        end
    endtask

    task automatic test_random();
        int w;
        do_reset();
        for (int k = 0; k < N_REQ; k++) begin
            req_valid[k] = 1'($urandom_range(0, 1));
            req_addr[k]  = AW'($urandom_range(0, 31));
            req_data[k]  = $urandom;
        end
        for (int c = 0; c < 400; c++) begin
            #1;
            n_checks++;
            if (req_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready cycle=%0d got %b required %b", c, req_ready, exp_ready());
            end
            w = model_win();
            clock_cycle();
            n_checks++;
            if ({wen, waddr, wdata, err_oor, wr_pending} !== {m_wen, m_waddr, m_wdata, m_err, exp_pending()}) begin
                n_fail++;
                $display("FAIL rand_out cycle=%0d got wen=%b waddr=%0d wdata=%h err=%b pend=%h required %b/%0d/%h/%b/%h",
                         c, wen, waddr, wdata, err_oor, wr_pending, m_wen, m_waddr, m_wdata, m_err, exp_pending());
            end
            // Producers hold a request until granted, then may issue a new one.
            for (int k = 0; k < N_REQ; k++) begin
                if (k == w || !req_valid[k]) begin
                    req_valid[k] = 1'($urandom_range(0, 1));
                    req_addr[k]  = AW'($urandom_range(0, 31));
                    req_data[k]  = $urandom;
                end
            end
        end
        req_valid = '0;
    endtask

`ifdef REGFILE_WR_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req_addr[1] = 5'd3; req_data[1] = $urandom;
        req_valid = 4'b0010;
        #1;
        repeat (65540) clock_cycle();
        n_checks++;
        if (grant_cnt[1] !== 16'hFFFF || int'(grant_cnt[1]) != m_cnt[1] || grant_cnt[0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL stats_sat got cnt1=%h cnt0=%h required ffff/0000", grant_cnt[1], grant_cnt[0]);
        end
        cnt_clr = 1'b1;
        clock_cycle();
        cnt_clr = 1'b0;
        n_checks++;
        if (grant_cnt[1] !== 16'h0000) begin
            n_fail++;
            $display("FAIL stats_clr got cnt1=%h required 0000", grant_cnt[1]);
        end
        clock_cycle();
        req_valid = '0;
        n_checks++;
        if (int'(grant_cnt[1]) != m_cnt[1] || grant_cnt[1] !== 16'h0001) begin
            n_fail++;
            $display("FAIL stats_inc got cnt1=%h required 0001", grant_cnt[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fairness();
        test_rotation();
        test_collision();
        test_out_of_range();
        test_random();
`ifdef REGFILE_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
